lut_const_mult_seq: RTL and testbench

Parametrised, sequential successor to the combinational 8-bit LUT constant multiplier. It multiplies an X_W-bit operand by a run-time-loadable A_W-bit constant, one nibble per cycle, using an 8-entry odd-multiple (OMS) LUT and shift-by-trailing-zeros decomposition. The LUT is built in hardware from the loaded constant. Inputs and outputs use valid/ready handshakes so the block drops into the datapath between a producer and an accumulator stage.

---
 rtl/lut_const_mult_seq.sv | 181 ++++++++++++++++++
 tb/tb_lut_const_mult_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lut_const_mult_seq.sv
// Multiplies an X_W-bit operand by a loadable A_W-bit constant, one nibble per cycle, via an 8-entry odd-multiple LUT.
// Latency: constant load = 8 fill cycles; multiply = NIB cycles from accept to out_valid.
// Backpressure: in_ready only in S_IDLE without a_load; p and out_valid held in S_DONE until out_ready.
// Optional feature macro: LUT_MULT_SIGNED_EN (two's-complement operand and product).
module lut_const_mult_seq #(
    parameter int X_W = 8,
    parameter int A_W = 8,
    localparam int P_W = X_W + A_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           a_load,
    input  logic [A_W-1:0] a_val,
    output logic           busy,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] p
);

    localparam int NIB = X_W / 4;
    localparam int LW  = A_W + 4;

    typedef enum logic [2:0] {
        S_INIT,
        S_FILL,
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [A_W-1:0] a_q, a_d;
    logic [LW-1:0]  lut_q [8];
    logic [LW-1:0]  lut_d [8];
    logic [2:0]     cnt_q, cnt_d;
    logic [X_W-1:0] x_q, x_d;
    logic [P_W-1:0] acc_q, acc_d;
    logic [P_W-1:0] p_q, p_d;

    logic           load_ok;
    logic           accept;
    logic           last_nib;
    logic [3:0]     nib;
    logic [3:0]     mag;
    logic           neg;
    logic [1:0]     tz;
    logic [2:0]     idx;
    logic [P_W-1:0] term;
    logic [P_W-1:0] acc_next;
    logic [LW-1:0]  twice_a;

    // A load is only honoured when no fill or multiply is in flight
    assign load_ok  = a_load && ((state_q == S_INIT) || (state_q == S_IDLE));
    assign accept   = in_valid && in_ready;
    assign last_nib = (cnt_q == 3'(NIB - 1));
    assign twice_a  = LW'({a_q, 1'b0});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (load_ok) state_d = S_FILL;
            S_FILL: if (cnt_q == 3'd7) state_d = S_IDLE;
            S_IDLE: begin
                if (load_ok) begin
                    state_d = S_FILL;
                end else if (accept) begin
                    state_d = S_MUL;
                end
            end
            S_MUL:  if (last_nib) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        busy      = (state_q == S_FILL);
        in_ready  = (state_q == S_IDLE) && !a_load;
        out_valid = (state_q == S_DONE);
    end

    // Current nibble decomposed into odd LUT index and shift (top nibble may be negative)
    always_comb begin
        nib = 4'(x_q >> {cnt_q, 2'b00});
`ifdef LUT_MULT_SIGNED_EN
        neg = last_nib && nib[3];
        mag = neg ? ((~nib) + 4'd1) : nib;
`else
        neg = 1'b0;
        mag = nib;
`endif
        if (mag[0]) begin
            tz = 2'd0;
        end else if (mag[1]) begin
            tz = 2'd1;
        end else if (mag[2]) begin
            tz = 2'd2;
        end else begin
            tz = 2'd3;
        end
        idx = 3'(mag >> ({1'b0, tz} + 3'd1));
        if (mag == 4'd0) begin
            term = '0;
        end else begin
            term = (P_W'(lut_q[idx]) << tz) << {cnt_q, 2'b00};
        end
        acc_next = neg ? (acc_q - term) : (acc_q + term);
    end

    // Datapath next values: constant capture, LUT fill, operand capture, accumulate
    always_comb begin
        a_d   = a_q;
        lut_d = lut_q;
        cnt_d = cnt_q;
        x_d   = x_q;
        acc_d = acc_q;
        p_d   = p_q;
        if (load_ok) begin
            a_d   = a_val;
            cnt_d = 3'd0;
        end else if (accept) begin
            x_d   = x;
            acc_d = '0;
            cnt_d = 3'd0;
        end else if (state_q == S_FILL) begin
            // Entry 0 is A itself; each later odd multiple adds 2A to its predecessor
            if (cnt_q == 3'd0) begin
                lut_d[0] = LW'(a_q);
            end else begin
                lut_d[cnt_q] = lut_q[cnt_q - 3'd1] + twice_a;
            end
            cnt_d = cnt_q + 3'd1;
        end else if (state_q == S_MUL) begin
            acc_d = acc_next;
            cnt_d = cnt_q + 3'd1;
            if (last_nib) begin
                p_d = acc_next;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            cnt_q <= '0;
            x_q   <= '0;
            acc_q <= '0;
            p_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            a_q   <= a_d;
            cnt_q <= cnt_d;
            x_q   <= x_d;
            acc_q <= acc_d;
            p_q   <= p_d;
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    assign p = p_q;

endmodule

// File: tb/tb_lut_const_mult_seq.sv
// Bench for lut_const_mult_seq with default widths (X_W = 8, A_W = 8).
// Inputs driven and outputs sampled on the falling clock edge.
// Expected products are hand-computed for both unsigned and signed builds.
module tb_lut_const_mult_seq;

    localparam int X_W = 8;
    localparam int A_W = 8;
    localparam int P_W = 16;

    logic           clk;
    logic           rst_n;
    logic           a_load;
    logic [A_W-1:0] a_val;
    logic           busy;
    logic           in_valid;
    logic           in_ready;
    logic [X_W-1:0] x;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] p;

    int n_checks = 0;
    int n_pass   = 0;

    lut_const_mult_seq #(.X_W(X_W), .A_W(A_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_load   (a_load),
        .a_val    (a_val),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  x;
        logic [15:0] exp_u;
        logic [15:0] exp_s;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Called at a falling edge with in_valid low; counts busy cycles after the load edge
    task automatic load_const(input logic [7:0] a);
        int cnt;
        a_load = 1'b1;
        a_val  = a;
        @(negedge clk);
        a_load = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check($sformatf("busy_cycles_a%0d", a), cnt, 8);
        check($sformatf("ready_after_fill_a%0d", a), {31'd0, in_ready}, 1);
    endtask

    // One multiply with out_ready high; leaves the DUT back in idle
    task automatic run_mul(input string tag, input logic [7:0] xv, input logic [15:0] exp);
        int cyc;
        check({tag, "_ready"}, {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        x        = xv;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2);
        check({tag, "_p"}, {16'd0, p}, {16'd0, exp});
        @(negedge clk);
        check({tag, "_out_valid_cleared"}, {31'd0, out_valid}, 0);
    endtask

    initial begin
        int cur_a;
        int cnt;
        logic seen;
        logic [15:0] exp;

        vecs[0] = '{a: 8'd2,   x: 8'h37, exp_u: 16'd110,   exp_s: 16'd110};
        vecs[1] = '{a: 8'd255, x: 8'hFF, exp_u: 16'd65025, exp_s: 16'hFF01};
        vecs[2] = '{a: 8'd255, x: 8'h00, exp_u: 16'd0,     exp_s: 16'd0};
        vecs[3] = '{a: 8'd255, x: 8'h80, exp_u: 16'd32640, exp_s: 16'd32896};
        vecs[4] = '{a: 8'd13,  x: 8'h80, exp_u: 16'd1664,  exp_s: 16'hF980};
        vecs[5] = '{a: 8'd13,  x: 8'h7F, exp_u: 16'd1651,  exp_s: 16'd1651};
        vecs[6] = '{a: 8'd13,  x: 8'hA5, exp_u: 16'd2145,  exp_s: 16'hFB61};
        vecs[7] = '{a: 8'd13,  x: 8'h01, exp_u: 16'd13,    exp_s: 16'd13};
        vecs[8] = '{a: 8'd1,   x: 8'hFF, exp_u: 16'd255,   exp_s: 16'hFFFF};
        vecs[9] = '{a: 8'd3,   x: 8'h4C, exp_u: 16'd228,   exp_s: 16'd228};

        rst_n     = 1'b0;
        a_load    = 1'b0;
        a_val     = '0;
        in_valid  = 1'b1;
        x         = 8'h37;
        out_ready = 1'b1;

        // Reset values, with an operand already offered
        repeat (3) @(negedge clk);
        check("rst_busy",      {31'd0, busy},      0);
        check("rst_in_ready",  {31'd0, in_ready},  0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_p",         {16'd0, p},         0);

        // No constant loaded yet: operand must never be taken
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready || out_valid) seen = 1'b1;
        end
        check("no_accept_without_load", {31'd0, seen}, 0);
        in_valid = 1'b0;

        // Table of directed products
        cur_a = -1;
        for (int i = 0; i < 10; i++) begin
            if (int'(vecs[i].a) != cur_a) begin
                load_const(vecs[i].a);
                cur_a = int'(vecs[i].a);
            end
`ifdef LUT_MULT_SIGNED_EN
            exp = vecs[i].exp_s;
`else
            exp = vecs[i].exp_u;
`endif
            run_mul($sformatf("vec%0d", i), vecs[i].x, exp);
        end

        // Backpressure: hold the result, refuse the next operand until the handshake
        load_const(8'd13);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x         = 8'h05;
        @(negedge clk);
        x   = 8'h02;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_latency", cnt, 2);
        check("bp_p", {16'd0, p}, 65);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_p_%0d", i), {16'd0, p}, 65);
            check($sformatf("bp_hold_ready_%0d", i), {31'd0, in_ready}, 0);
            check($sformatf("bp_hold_valid_%0d", i), {31'd0, out_valid}, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_handshake", {31'd0, in_ready}, 1);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("bp_second_latency", cnt, 2);
        check("bp_second_p", {16'd0, p}, 26);
        @(negedge clk);

        // Load and operand together in idle: the load wins
        a_load   = 1'b1;
        a_val    = 8'd3;
        in_valid = 1'b1;
        x        = 8'h11;
        #1;
        check("load_wins_ready_low", {31'd0, in_ready}, 0);
        @(negedge clk);
        a_load   = 1'b0;
        in_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        check("load_wins_busy_cycles", cnt, 8);
        run_mul("load_wins_mul", 8'h10, 16'd48);

        // Reset in the middle of a multiply
        in_valid = 1'b1;
        x        = 8'h37;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_p",         {16'd0, p},         0);
        check("midrst_busy",      {31'd0, busy},      0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b1;
        seen     = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready || out_valid) seen = 1'b1;
        end
        check("midrst_no_accept", {31'd0, seen}, 0);
        in_valid = 1'b0;
        load_const(8'd2);
        run_mul("midrst_recover", 8'h37, 16'd110);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
